// File: rtl/mvu_pkg.sv
// ---------------------------------------------------------------------------
// mvu_pkg
// Shared definitions for the MVU job dispatcher and the MVU task controller.
//   BCNTDWN_DEF : default job countdown width (must match the controller)
//   QADDR_DEF   : default log2 of the job queue depth
//   BJOBS_DEF   : default width of the completed-job counter
//   mvu_state_e : one-hot dispatcher FSM state encoding
// ---------------------------------------------------------------------------
package mvu_pkg;

    localparam int unsigned BCNTDWN_DEF = 29;
    localparam int unsigned QADDR_DEF   = 2;
    localparam int unsigned BJOBS_DEF   = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_ARMED  = 4'b0100,
        S_BUSY   = 4'b1000
    } mvu_state_e;

endpackage

// File: rtl/mvu_job_fifo.sv
// ---------------------------------------------------------------------------
// mvu_job_fifo
// Circular job queue of 2**QADDR entries, QADDR-bit pointers plus a full bit.
//   clk, clr_n  : clock, asynchronous active-low reset
//   push_i      : enqueue wdata_i (ignored when full or flushing)
//   pop_i       : drop the head entry (ignored when empty or flushing)
//   flush_i     : empty the queue at the next edge; beats push and pop
//   wdata_i     : entry to enqueue
//   rdata_o     : current head entry
//   full_o      : queue holds 2**QADDR entries
//   empty_o     : queue holds no entries
//   level_o     : number of entries held
// ---------------------------------------------------------------------------
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter int unsigned WIDTH = BCNTDWN_DEF,
    parameter int unsigned QADDR = QADDR_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [QADDR:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** QADDR;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [QADDR-1:0] wr_q;
    logic [QADDR-1:0] rd_q;
    logic             full_q;
    logic [QADDR-1:0] wr_inc;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q) && !full_q;
    assign full_o  = full_q;
    assign rdata_o = mem_q[rd_q];
    assign wr_inc  = wr_q + 1'b1;
    assign do_push = push_i && !full_q && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Equal pointers are ambiguous; the full bit tells a full queue from an empty one.
    always_comb begin
        level_o = '0;
        if (full_q) begin
            level_o = {1'b1, {QADDR{1'b0}}};
        end else begin
            level_o = {1'b0, wr_q - rd_q};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            full_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_inc;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop && (wr_inc == rd_q)) begin
                full_q <= 1'b1;
            end else if (do_pop && !do_push) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// ---------------------------------------------------------------------------
// mvu_job_dispatcher
// Queues CPU job countdowns and launches them one at a time on the MVU task
// controller, raising one interrupt when a batch drains.
//   clk, clr_n        : clock, asynchronous active-low reset
//   cmd_valid         : CPU offers cmd_countdown this cycle
//   cmd_countdown     : job length in controller step cycles (0 is rejected)
//   cmd_ready         : queue not full
//   flush             : discard queued, not-yet-launched jobs
//   mvu_start         : one-cycle start pulse to the controller
//   mvu_countdown     : countdown for the controller, held until next launch
//   mvu_run, mvu_irq  : controller run level and done pulse
//   irq, irq_ack      : batch-complete interrupt and its clear
//   busy              : job in flight or queue non-empty
//   q_level           : queued job count
//   jobs_done         : completed jobs, wrapping
//   err_zero          : sticky, a zero countdown was offered
//   err_proto         : sticky, mvu_run missing the cycle after start
// ---------------------------------------------------------------------------
module mvu_job_dispatcher
    import mvu_pkg::*;
#(
    parameter int unsigned BCNTDWN = BCNTDWN_DEF,
    parameter int unsigned QADDR   = QADDR_DEF,
    parameter int unsigned BJOBS   = BJOBS_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               cmd_valid,
    input  logic [BCNTDWN-1:0] cmd_countdown,
    output logic               cmd_ready,
    input  logic               flush,
    output logic               mvu_start,
    output logic [BCNTDWN-1:0] mvu_countdown,
    input  logic               mvu_run,
    input  logic               mvu_irq,
    output logic               irq,
    input  logic               irq_ack,
    output logic               busy,
    output logic [QADDR:0]     q_level,
    output logic [BJOBS-1:0]   jobs_done,
    output logic               err_zero,
    output logic               err_proto
);

    mvu_state_e         state_q;
    logic               start_q;
    logic [BCNTDWN-1:0] cd_q;
    logic               irq_q;
    logic [BJOBS-1:0]   jobs_q;
    logic               err_zero_q;
    logic               err_proto_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [BCNTDWN-1:0] fifo_rdata;
    logic               cmd_take;
    logic               cmd_zero;
    logic               fifo_push;
    logic               fifo_pop;

    assign cmd_ready = !fifo_full;
    assign cmd_take  = cmd_valid && cmd_ready;
    assign cmd_zero  = (cmd_countdown == '0);
    // A zero countdown would wrap the controller counter, so it never enters the queue.
    assign fifo_push = cmd_take && !cmd_zero && !flush;
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty && !flush;

    mvu_job_fifo #(
        .WIDTH (BCNTDWN),
        .QADDR (QADDR)
    ) u_fifo (
        .clk     (clk),
        .clr_n   (clr_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .wdata_i (cmd_countdown),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (q_level)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            cd_q        <= '0;
            irq_q       <= 1'b0;
            jobs_q      <= '0;
            err_zero_q  <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            start_q <= 1'b0;

            if (cmd_take && cmd_zero) begin
                err_zero_q <= 1'b1;
            end

            // Only the completion that leaves the queue empty ends a batch; set beats ack.
            if ((state_q == S_BUSY) && mvu_irq && fifo_empty) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        cd_q    <= fifo_rdata;
                        start_q <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_ARMED;
                end
                S_ARMED: begin
                    if (mvu_run) begin
                        state_q <= S_BUSY;
                    end else begin
                        err_proto_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (mvu_irq) begin
                        jobs_q  <= jobs_q + 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mvu_start     = start_q;
    assign mvu_countdown = cd_q;
    assign irq           = irq_q;
    assign jobs_done     = jobs_q;
    assign err_zero      = err_zero_q;
    assign err_proto     = err_proto_q;
    assign busy          = (state_q != S_IDLE) || (q_level != '0);

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_mvu_job_dispatcher
// Directed bench for mvu_job_dispatcher with a behavioural controller model:
// run rises after a start, and a one-cycle done pulse follows once the
// countdown has elapsed, with run held through the done pulse.
// ---------------------------------------------------------------------------
module tb_mvu_job_dispatcher;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        cmd_valid;
    logic [28:0] cmd_countdown;
    logic        cmd_ready;
    logic        flush;
    logic        mvu_start;
    logic [28:0] mvu_countdown;
    logic        mvu_run = 1'b0;
    logic        mvu_irq = 1'b0;
    logic        irq;
    logic        irq_ack;
    logic        busy;
    logic [2:0]  q_level;
    logic [7:0]  jobs_done;
    logic        err_zero;
    logic        err_proto;

    mvu_job_dispatcher #(
        .BCNTDWN (29),
        .QADDR   (2),
        .BJOBS   (8)
    ) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .cmd_valid     (cmd_valid),
        .cmd_countdown (cmd_countdown),
        .cmd_ready     (cmd_ready),
        .flush         (flush),
        .mvu_start     (mvu_start),
        .mvu_countdown (mvu_countdown),
        .mvu_run       (mvu_run),
        .mvu_irq       (mvu_irq),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .busy          (busy),
        .q_level       (q_level),
        .jobs_done     (jobs_done),
        .err_zero      (err_zero),
        .err_proto     (err_proto)
    );

    always #5 clk = ~clk;

    // Observation and controller state, all owned by the negedge process.
    int          cyc = 0;
    int          starts = 0;
    int          start_cyc = 0;
    int          irq_cyc = 0;
    int          n_gaps = 0;
    int          gap_bad = 0;
    int          cd_unstable = 0;
    int          irq_rises = 0;
    int          irq_rise_cyc = 0;
    logic [28:0] last_cd = '0;
    logic [28:0] prev_cd = '0;
    logic [29:0] ctl_cnt = '0;
    bit          prev_irq = 1'b0;
    bit          irq_pend_next = 1'b0;

    // Controls written only by the main initial block.
    bit          ctl_en = 1'b1;
    bit          ctl_kill = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mvu_start) begin
            starts++;
            if (irq_pend_next) begin
                n_gaps++;
                if (cyc - irq_cyc != 2) gap_bad++;
                irq_pend_next = 1'b0;
            end
            start_cyc = cyc;
            last_cd   = mvu_countdown;
        end
        if (clr_n && !mvu_start && (mvu_countdown != prev_cd)) cd_unstable++;
        prev_cd = mvu_countdown;
        if (irq && !prev_irq) begin
            irq_rises++;
            irq_rise_cyc = cyc;
        end
        prev_irq = irq;

        if (ctl_kill) begin
            mvu_run = 1'b0;
            mvu_irq = 1'b0;
        end else begin
            if (mvu_irq) begin
                mvu_irq = 1'b0;
                mvu_run = 1'b0;
            end else if (mvu_run) begin
                if (ctl_cnt == 30'd1) begin
                    mvu_irq       = 1'b1;
                    irq_cyc       = cyc;
                    irq_pend_next = (q_level != 3'd0);
                end else begin
                    ctl_cnt = ctl_cnt - 30'd1;
                end
            end
            if (mvu_start && ctl_en) begin
                mvu_run = 1'b1;
                ctl_cnt = {1'b0, mvu_countdown} + 30'd1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [28:0] cd);
        cmd_valid     = 1'b1;
        cmd_countdown = cd;
        tick();
        cmd_valid     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < 400)) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
        tick();
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    int push_cyc;
    int s0;
    int g0;
    int r0;

    initial begin
        clr_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_countdown = '0;
        flush         = 1'b0;
        irq_ack       = 1'b0;
        repeat (3) tick();

        check("rst_start", mvu_start, 0);
        check("rst_irq", irq, 0);
        check("rst_busy", busy, 0);
        check("rst_qlevel", q_level, 0);
        check("rst_jobs", jobs_done, 0);
        check("rst_cd", mvu_countdown, 0);
        check("rst_errz", err_zero, 0);
        check("rst_errp", err_proto, 0);
        check("rst_ready", cmd_ready, 1);
        clr_n = 1'b1;
        tick();

        // Single job
        push_cyc = cyc + 1;
        push(29'd3);
        check("single_qlevel", q_level, 1);
        wait_idle("single_timeout");
        check("single_starts", starts, 1);
        check("single_latency", start_cyc - push_cyc, 2);
        check("single_cd", last_cd, 3);
        check("single_cd_stable", cd_unstable, 0);
        check("single_jobs", jobs_done, 1);
        check("single_irq", irq, 1);
        check("single_irq_lat", irq_rise_cyc - irq_cyc, 1);
        ack_irq();
        check("single_ack", irq, 0);

        // Batch: long job launches, then four more fill the queue
        s0 = starts; g0 = n_gaps; r0 = irq_rises;
        push(29'd20);
        push(29'd5);
        push(29'd1);
        push(29'd2);
        push(29'd7);
        check("batch_full_level", q_level, 4);
        check("batch_ready_low", cmd_ready, 0);
        cmd_valid     = 1'b1;
        cmd_countdown = 29'd9;
        tick();
        cmd_valid     = 1'b0;
        check("batch_full_hold", q_level, 4);
        check("batch_no_early_irq", irq, 0);
        wait_idle("batch_timeout");
        check("batch_starts", starts - s0, 5);
        check("batch_gaps", n_gaps - g0, 4);
        check("batch_gap_bad", gap_bad, 0);
        check("batch_irq_once", irq_rises - r0, 1);
        check("batch_irq", irq, 1);
        check("batch_jobs", jobs_done, 6);
        check("batch_last_cd", last_cd, 7);
        check("batch_cd_stable", cd_unstable, 0);
        ack_irq();

        // Zero countdown
        check("zero_err_before", err_zero, 0);
        s0 = starts;
        push(29'd0);
        check("zero_level", q_level, 0);
        check("zero_err", err_zero, 1);
        push(29'd4);
        check("zero_level4", q_level, 1);
        wait_idle("zero_timeout");
        check("zero_starts", starts - s0, 1);
        check("zero_cd", last_cd, 4);
        check("zero_jobs", jobs_done, 7);
        ack_irq();

        // Protocol error: controller ignores the first launch
        ctl_en = 1'b0;
        s0 = starts;
        push(29'd6);
        push(29'd8);
        tick();
        check("proto_err_before", err_proto, 0);
        tick();
        check("proto_err", err_proto, 1);
        check("proto_jobs", jobs_done, 7);
        check("proto_qlevel", q_level, 1);
        check("proto_busy", busy, 1);
        ctl_en = 1'b1;
        wait_idle("proto_timeout");
        check("proto_starts", starts - s0, 2);
        check("proto_cd", last_cd, 8);
        check("proto_jobs_after", jobs_done, 8);
        check("proto_sticky", err_proto, 1);
        ack_irq();

        // Flush during a running job
        s0 = starts;
        push(29'd30);
        push(29'd3);
        push(29'd4);
        check("flush_level_pre", q_level, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", q_level, 0);
        check("flush_busy", busy, 1);
        wait_idle("flush_timeout");
        check("flush_starts", starts - s0, 1);
        check("flush_cd", last_cd, 30);
        check("flush_jobs", jobs_done, 9);
        check("flush_irq", irq, 1);
        ack_irq();

        // Flush beats a simultaneous push
        flush         = 1'b1;
        cmd_valid     = 1'b1;
        cmd_countdown = 29'd5;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("flushpush_level", q_level, 0);
        check("flushpush_busy", busy, 0);
        s0 = starts;
        repeat (4) tick();
        check("flushpush_starts", starts - s0, 0);
        check("flushpush_irq", irq, 0);

        // Asynchronous reset while a job is running
        push(29'd10);
        push(29'd12);
        repeat (3) tick();
        check("rstmid_busy_pre", busy, 1);
        s0 = starts;
        #2;
        ctl_kill = 1'b1;
        clr_n    = 1'b0;
        #1;
        check("rstmid_start", mvu_start, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_qlevel", q_level, 0);
        check("rstmid_jobs", jobs_done, 0);
        check("rstmid_cd", mvu_countdown, 0);
        check("rstmid_errz", err_zero, 0);
        check("rstmid_errp", err_proto, 0);
        check("rstmid_irq", irq, 0);
        check("rstmid_ready", cmd_ready, 1);
        repeat (2) tick();
        clr_n    = 1'b1;
        ctl_kill = 1'b0;
        repeat (6) tick();
        check("rstmid_no_start", starts - s0, 0);
        check("rstmid_idle", busy, 0);
        check("rstmid_qlevel_after", q_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
